// File: rtl/tta_alu_pkg.sv
// Shared types and constants for TTA ALU function-unit sharing blocks.
package tta_alu_pkg;

  localparam int unsigned DATAW = 32;
  localparam int unsigned OPCW  = 4;

  // ALU opcodes; 13..15 fall through to the FU's compare path
  localparam logic [OPCW-1:0] OPC_ADD  = OPCW'(0);
  localparam logic [OPCW-1:0] OPC_AND  = OPCW'(1);
  localparam logic [OPCW-1:0] OPC_EQ   = OPCW'(2);
  localparam logic [OPCW-1:0] OPC_GT   = OPCW'(3);
  localparam logic [OPCW-1:0] OPC_GTU  = OPCW'(4);
  localparam logic [OPCW-1:0] OPC_IOR  = OPCW'(5);
  localparam logic [OPCW-1:0] OPC_SHL  = OPCW'(6);
  localparam logic [OPCW-1:0] OPC_SHR  = OPCW'(7);
  localparam logic [OPCW-1:0] OPC_SHRU = OPCW'(8);
  localparam logic [OPCW-1:0] OPC_SUB  = OPCW'(9);
  localparam logic [OPCW-1:0] OPC_SXHW = OPCW'(10);
  localparam logic [OPCW-1:0] OPC_SXQW = OPCW'(11);
  localparam logic [OPCW-1:0] OPC_XOR  = OPCW'(12);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_CAPT  = 2'd2,
    ST_RESP  = 2'd3
  } arb_state_e;

  // One latched request: opcode, trigger operand a, second operand b
  typedef struct packed {
    logic [OPCW-1:0]  opcode;
    logic [DATAW-1:0] a;
    logic [DATAW-1:0] b;
  } alu_req_t;

endpackage

// File: rtl/rr_arbiter_nreq.sv
// Combinational round-robin pick: first set request at or after ptr, wrapping.
module rr_arbiter_nreq #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned IDW  = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  output logic [NREQ-1:0] grant,
  output logic [IDW-1:0]  grant_idx,
  output logic            grant_valid
);

  logic           hi_valid;
  logic [IDW-1:0] hi_idx;
  logic [IDW-1:0] lo_idx;

  // Descending scan: lowest request overall (wrap case) and lowest at/after ptr
  always_comb begin
    hi_valid    = 1'b0;
    hi_idx      = '0;
    lo_idx      = '0;
    grant_valid = 1'b0;
    grant       = '0;
    for (int i = int'(NREQ) - 1; i >= 0; i--) begin
      if (req[i]) begin
        grant_valid = 1'b1;
        lo_idx      = IDW'(i);
        if (i >= int'(ptr)) begin
          hi_valid = 1'b1;
          hi_idx   = IDW'(i);
        end
      end
    end
    grant_idx = hi_valid ? hi_idx : lo_idx;
    if (grant_valid) grant[grant_idx] = 1'b1;
  end

endmodule

// File: rtl/fu_alu_share_arb.sv
// Shares one latency-1 ALU function unit among NREQ requesters, round-robin,
// one operation in flight. Optional perf counters: define FU_ARB_PERFCNT_EN.
module fu_alu_share_arb
  import tta_alu_pkg::*;
#(
  parameter int unsigned NREQ = 4,
  parameter int unsigned IDW  = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [NREQ*OPCW-1:0]  req_opcode,
  input  logic [NREQ*DATAW-1:0] req_a,
  input  logic [NREQ*DATAW-1:0] req_b,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [IDW-1:0]        resp_id,
  output logic [DATAW-1:0]      resp_data,
  output logic [DATAW-1:0]      fu_t1data,
  output logic [OPCW-1:0]       fu_t1opcode,
  output logic                  fu_t1load,
  output logic [DATAW-1:0]      fu_o1data,
  output logic                  fu_o1load,
  input  logic [DATAW-1:0]      fu_r1data,
`ifdef FU_ARB_PERFCNT_EN
  output logic [31:0]           perf_busy,
  output logic [31:0]           perf_lock,
`endif
  input  logic                  glock
);

  arb_state_e      state_q, state_d;
  logic [IDW-1:0]  rr_q, rr_d;
  logic [IDW-1:0]  id_q, id_d;
  alu_req_t        hold_q, hold_d;
  logic [NREQ-1:0] req_ready_d;
  logic            resp_valid_d;
  logic [IDW-1:0]  resp_id_d;
  logic [DATAW-1:0] resp_data_d;

  logic [NREQ-1:0] win_grant;
  logic [IDW-1:0]  win_idx;
  logic            win_valid;
  alu_req_t        win_req;

  rr_arbiter_nreq #(.NREQ(NREQ), .IDW(IDW)) u_arb (
    .req        (req_valid),
    .ptr        (rr_q),
    .grant      (win_grant),
    .grant_idx  (win_idx),
    .grant_valid(win_valid)
  );

  // Select the winning requester's payload
  always_comb begin
    win_req = '0;
    for (int i = 0; i < int'(NREQ); i++) begin
      if (win_idx == IDW'(i)) begin
        win_req.opcode = req_opcode[i*OPCW +: OPCW];
        win_req.a      = req_a[i*DATAW +: DATAW];
        win_req.b      = req_b[i*DATAW +: DATAW];
      end
    end
  end

  // State, pointer, holding and response registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      rr_q       <= '0;
      id_q       <= '0;
      hold_q     <= '0;
      req_ready  <= '0;
      resp_valid <= 1'b0;
      resp_id    <= '0;
      resp_data  <= '0;
    end else begin
      state_q    <= state_d;
      rr_q       <= rr_d;
      id_q       <= id_d;
      hold_q     <= hold_d;
      req_ready  <= req_ready_d;
      resp_valid <= resp_valid_d;
      resp_id    <= resp_id_d;
      resp_data  <= resp_data_d;
    end
  end

  // Next-state and register-update decode
  always_comb begin
    state_d      = state_q;
    rr_d         = rr_q;
    id_d         = id_q;
    hold_d       = hold_q;
    req_ready_d  = '0;
    resp_valid_d = resp_valid;
    resp_id_d    = resp_id;
    resp_data_d  = resp_data;
    unique case (state_q)
      ST_IDLE: begin
        if (win_valid) begin
          req_ready_d = win_grant;
          hold_d      = win_req;
          id_d        = win_idx;
          rr_d        = (win_idx == IDW'(NREQ - 1)) ? '0 : win_idx + IDW'(1);
          state_d     = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (!glock) state_d = ST_CAPT;
      end
      ST_CAPT: begin
        if (!glock) begin
          resp_data_d  = fu_r1data;
          resp_id_d    = id_q;
          resp_valid_d = 1'b1;
          state_d      = ST_RESP;
        end
      end
      ST_RESP: begin
        if (resp_ready) begin
          resp_valid_d = 1'b0;
          state_d      = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // FU data follows the holding regs; only the strobes depend on state
  assign fu_t1data   = hold_q.a;
  assign fu_o1data   = hold_q.b;
  assign fu_t1opcode = hold_q.opcode;
  assign fu_t1load   = (state_q == ST_ISSUE);
  assign fu_o1load   = (state_q == ST_ISSUE);

`ifdef FU_ARB_PERFCNT_EN
  // Saturating busy and glock-stall cycle counters
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      perf_busy <= '0;
      perf_lock <= '0;
    end else begin
      if (state_q != ST_IDLE && perf_busy != 32'hFFFF_FFFF)
        perf_busy <= perf_busy + 32'd1;
      if ((state_q == ST_ISSUE || state_q == ST_CAPT) && glock && perf_lock != 32'hFFFF_FFFF)
        perf_lock <= perf_lock + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fu_alu_share_arb.sv
// Directed bench for fu_alu_share_arb with a small latency-1 ALU FU model.
module tb_fu_alu_share_arb;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic [3:0]   req_valid = '0;
  logic [3:0]   req_ready;
  logic [15:0]  req_opcode = '0;
  logic [127:0] req_a = '0;
  logic [127:0] req_b = '0;
  logic         resp_valid;
  logic         resp_ready = 1'b1;
  logic [1:0]   resp_id;
  logic [31:0]  resp_data;
  logic [31:0]  fu_t1data;
  logic [3:0]   fu_t1opcode;
  logic         fu_t1load;
  logic [31:0]  fu_o1data;
  logic         fu_o1load;
  logic [31:0]  fu_r1data;
  logic         glock = 1'b0;
`ifdef FU_ARB_PERFCNT_EN
  logic [31:0]  perf_busy;
  logic [31:0]  perf_lock;
`endif

  int checks = 0;
  int errors = 0;

  fu_alu_share_arb #(.NREQ(4), .IDW(2)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_opcode(req_opcode), .req_a(req_a), .req_b(req_b),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_id(resp_id), .resp_data(resp_data),
    .fu_t1data(fu_t1data), .fu_t1opcode(fu_t1opcode), .fu_t1load(fu_t1load),
    .fu_o1data(fu_o1data), .fu_o1load(fu_o1load), .fu_r1data(fu_r1data),
`ifdef FU_ARB_PERFCNT_EN
    .perf_busy(perf_busy), .perf_lock(perf_lock),
`endif
    .glock(glock)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] alu_ref(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      4'd0:    alu_ref = a + b;
      4'd1:    alu_ref = a & b;
      4'd5:    alu_ref = a | b;
      4'd9:    alu_ref = a - b;
      4'd12:   alu_ref = a ^ b;
      default: alu_ref = {31'd0, a == b};
    endcase
  endfunction

  // FU model: o1 register, trigger computes into r1, everything frozen by glock
  logic [31:0] fu_o1_q = '0;
  logic [31:0] fu_r1_q = '0;
  always @(posedge clk) begin
    if (!glock) begin
      if (fu_o1load) fu_o1_q <= fu_o1data;
      if (fu_t1load) fu_r1_q <= alu_ref(fu_t1opcode, fu_t1data, fu_o1load ? fu_o1data : fu_o1_q);
    end
  end
  assign fu_r1data = fu_r1_q;

  task automatic set_req(input int i, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    req_opcode[i*4 +: 4] = op;
    req_a[i*32 +: 32]    = a;
    req_b[i*32 +: 32]    = b;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic wait_grant(output logic [3:0] g, output bit ok);
    ok = 1'b0;
    g  = '0;
    for (int k = 0; k < 20 && !ok; k++) begin
      @(negedge clk);
      if (req_ready != 4'b0) begin
        ok = 1'b1;
        g  = req_ready;
      end
    end
  endtask

  task automatic wait_resp(output bit ok);
    ok = 1'b0;
    for (int k = 0; k < 20 && !ok; k++) begin
      @(negedge clk);
      if (resp_valid) ok = 1'b1;
    end
  endtask

  // Reset values, then reset asserted while a response is pending
  task automatic test_reset();
    logic [3:0] g;
    bit ok;
    @(negedge clk);
    checks++; if ({resp_valid, req_ready, fu_t1load, fu_o1load} !== 7'b0) begin errors++; $display("FAIL reset_ctl: got %b want 0", {resp_valid, req_ready, fu_t1load, fu_o1load}); end
    checks++; if ({resp_data, resp_id, fu_t1data, fu_o1data} !== 98'b0) begin errors++; $display("FAIL reset_data: got %h want 0", {resp_data, resp_id, fu_t1data, fu_o1data}); end
    reset = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    set_req(1, 4'd0, 32'd1, 32'd2);
    req_valid = 4'b0010;
    wait_grant(g, ok);
    req_valid = 4'b0;
    checks++; if (!ok || g !== 4'b0010) begin errors++; $display("FAIL reset_pre_grant: got %b want 0010", g); end
    wait_resp(ok);
    checks++; if (!ok) begin errors++; $display("FAIL reset_pre_resp: no resp_valid within budget"); end
    #2 reset = 1'b0;
    #1;
    checks++; if ({resp_valid, fu_t1load, fu_o1load, req_ready} !== 7'b0) begin errors++; $display("FAIL reset_mid_resp: got %b want 0", {resp_valid, fu_t1load, fu_o1load, req_ready}); end
    req_valid = 4'b0101;
    @(negedge clk);
    reset = 1'b1;
    wait_grant(g, ok);
    req_valid = 4'b0;
    checks++; if (!ok || g !== 4'b0001) begin errors++; $display("FAIL reset_first_grant: got %b want 0001", g); end
    resp_ready = 1'b1;
    wait_resp(ok);
    checks++; if (!ok || resp_data !== 32'd0 || resp_id !== 2'd0) begin errors++; $display("FAIL reset_req0_resp: got id %0d data %h want id 0 data 0", resp_id, resp_data); end
    @(negedge clk);
  endtask

  // Single ADD from requester 1 with exact cycle timing
  task automatic test_add();
    resp_ready = 1'b1;
    set_req(1, 4'd0, 32'd5, 32'd7);
    req_valid = 4'b0010;
    @(negedge clk);
    checks++; if (req_ready !== 4'b0010) begin errors++; $display("FAIL add_ready: got %b want 0010", req_ready); end
    checks++; if ({fu_t1load, fu_o1load, fu_t1opcode, fu_t1data, fu_o1data} !== {2'b11, 4'd0, 32'd5, 32'd7}) begin errors++; $display("FAIL add_issue: got %b %b %h %h %h want 1 1 0 5 7", fu_t1load, fu_o1load, fu_t1opcode, fu_t1data, fu_o1data); end
    req_valid = 4'b0;
    @(negedge clk);
    checks++; if ({fu_t1load, fu_o1load, resp_valid, req_ready} !== 7'b0) begin errors++; $display("FAIL add_capt: got %b want 0", {fu_t1load, fu_o1load, resp_valid, req_ready}); end
    @(negedge clk);
    checks++; if ({resp_valid, resp_id, resp_data} !== {1'b1, 2'd1, 32'd12}) begin errors++; $display("FAIL add_resp: got v %b id %0d data %0d want v 1 id 1 data 12", resp_valid, resp_id, resp_data); end
    @(negedge clk);
    checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL add_resp_done: got %b want 0", resp_valid); end
  endtask

  // SUB from requester 0 with glock high for three ISSUE cycles
  task automatic test_glock();
    int lc;
    do_reset();
    resp_ready = 1'b0;
    set_req(0, 4'd9, 32'd3, 32'd5);
    req_valid = 4'b0001;
    @(negedge clk);
    checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL glock_ready: got %b want 0001", req_ready); end
    req_valid = 4'b0;
    glock = 1'b1;
    lc = 0;
    for (int k = 0; k < 5; k++) begin
      if (fu_t1load && fu_o1load) lc++;
      if (k == 3) glock = 1'b0;
      @(negedge clk);
    end
    checks++; if (lc !== 4) begin errors++; $display("FAIL glock_load_cycles: got %0d want 4", lc); end
    checks++; if ({resp_valid, resp_id, resp_data} !== {1'b1, 2'd0, 32'hFFFF_FFFE}) begin errors++; $display("FAIL glock_resp: got v %b id %0d data %h want v 1 id 0 data fffffffe", resp_valid, resp_id, resp_data); end
    @(negedge clk);
    resp_ready = 1'b1;
    @(negedge clk);
    checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL glock_resp_done: got %b want 0", resp_valid); end
`ifdef FU_ARB_PERFCNT_EN
    checks++; if (perf_busy !== 32'd7) begin errors++; $display("FAIL perf_busy: got %0d want 7", perf_busy); end
    checks++; if (perf_lock !== 32'd3) begin errors++; $display("FAIL perf_lock: got %0d want 3", perf_lock); end
`endif
  endtask

  // All four requesting continuously: strict rotation 0,1,2,3,0
  task automatic test_round_robin();
    logic [3:0] g;
    bit ok;
    do_reset();
    resp_ready = 1'b1;
    for (int i = 0; i < 4; i++) set_req(i, 4'd0, 32'(i * 10), 32'd1);
    req_valid = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      wait_grant(g, ok);
      checks++; if (!ok || g !== 4'(1 << (k % 4))) begin errors++; $display("FAIL rr_grant%0d: got %b want %b", k, g, 4'(1 << (k % 4))); end
      wait_resp(ok);
      checks++; if (!ok || resp_id !== 2'(k % 4) || resp_data !== 32'((k % 4) * 10 + 1)) begin errors++; $display("FAIL rr_resp%0d: got id %0d data %0d want id %0d data %0d", k, resp_id, resp_data, k % 4, (k % 4) * 10 + 1); end
    end
    req_valid = 4'b0;
    @(negedge clk);
  endtask

  // Response back-pressure: result held, no new grant until handshake
  task automatic test_back_to_back();
    logic [3:0] g;
    bit ok;
    resp_ready = 1'b0;
    set_req(2, 4'd12, 32'h0000_00F0, 32'h0000_00FF);
    set_req(3, 4'd0, 32'd100, 32'd23);
    req_valid = 4'b1100;
    wait_grant(g, ok);
    req_valid = 4'b1000;
    checks++; if (!ok || g !== 4'b0100) begin errors++; $display("FAIL bp_grant2: got %b want 0100", g); end
    wait_resp(ok);
    checks++; if (!ok || resp_id !== 2'd2 || resp_data !== 32'h0000_000F) begin errors++; $display("FAIL bp_resp2: got id %0d data %h want id 2 data f", resp_id, resp_data); end
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      checks++; if ({resp_valid, resp_id, resp_data, req_ready} !== {1'b1, 2'd2, 32'h0000_000F, 4'b0}) begin errors++; $display("FAIL bp_hold%0d: got v %b id %0d data %h ready %b want v 1 id 2 data f ready 0", k, resp_valid, resp_id, resp_data, req_ready); end
    end
    resp_ready = 1'b1;
    wait_grant(g, ok);
    req_valid = 4'b0;
    checks++; if (!ok || g !== 4'b1000) begin errors++; $display("FAIL bp_grant3: got %b want 1000", g); end
    wait_resp(ok);
    checks++; if (!ok || resp_id !== 2'd3 || resp_data !== 32'd123) begin errors++; $display("FAIL bp_resp3: got id %0d data %0d want id 3 data 123", resp_id, resp_data); end
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_add();
    test_glock();
    test_round_robin();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
